// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding, parity constants and voter helper for the UART receiver
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[1] & s[2]) | (s[0] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, frame configuration and received-byte outputs of the UART receiver
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);

    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESCALE_W-1:0] Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Parity_Error;
    logic                  Stop_Error;

    modport master (
        output RX_IN,
        output PAR_EN,
        output PAR_TYP,
        output Prescale,
        input  P_DATA,
        input  Data_Valid,
        input  Parity_Error,
        input  Stop_Error
    );

    modport slave (
        input  RX_IN,
        input  PAR_EN,
        input  PAR_TYP,
        input  Prescale,
        output P_DATA,
        output Data_Valid,
        output Parity_Error,
        output Stop_Error
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit edge/bit counters and three-sample majority voter around mid-bit
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cnt_en,
    input  logic                  cnt_clr,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  rx_in,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  bit_done,
    output logic                  sampled_bit
);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last_edge;
    logic [2:0]            samples;

    assign half        = prescale >> 1;
    assign last_edge   = prescale - PRESCALE_W'(1);
    assign bit_done    = cnt_en && (edge_cnt == last_edge);
    assign sampled_bit = majority3(samples);

    // A clear wins over counting so a frame that re-enters START on its last edge restarts at bit 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (cnt_en) begin
            if (bit_done) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + BIT_W'(1);
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samples <= 3'b111;
        end else if (cnt_en) begin
            if (edge_cnt == half - PRESCALE_W'(1)) samples[0] <= rx_in;
            if (edge_cnt == half)                  samples[1] <= rx_in;
            if (edge_cnt == half + PRESCALE_W'(1)) samples[2] <= rx_in;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: frame FSM, LSB-first shift register, parity and stop checks
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave rx_if
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 3);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic                  start_entry;
    logic                  cnt_en;
    logic                  cnt_clr;
    logic                  bit_done;
    logic                  sampled_bit;
    logic [BIT_W-1:0]      bit_cnt;

    logic [PRESCALE_W-1:0] prescale_l;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic                  par_err_flag;
    logic                  par_expected;
    logic [DATA_WIDTH-1:0] shift_reg;

    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  parity_error_q;
    logic                  stop_error_q;

    assign cnt_en       = (state != ST_IDLE);
    assign cnt_clr      = start_entry || (state_nxt == ST_IDLE);
    assign par_expected = (^shift_reg) ^ (par_typ_l == PAR_ODD);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_W      (BIT_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .cnt_en      (cnt_en),
        .cnt_clr     (cnt_clr),
        .prescale    (prescale_l),
        .rx_in       (rx_if.RX_IN),
        .bit_cnt     (bit_cnt),
        .bit_done    (bit_done),
        .sampled_bit (sampled_bit)
    );

    always_comb begin
        state_nxt   = state;
        start_entry = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_if.RX_IN) begin
                    state_nxt   = ST_START;
                    start_entry = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) state_nxt = sampled_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_done && (bit_cnt == BIT_W'(DATA_WIDTH)))
                    state_nxt = par_en_l ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_done) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // A low line on the last stop edge is already the next start bit.
                if (bit_done) begin
                    if (!rx_if.RX_IN) begin
                        state_nxt   = ST_START;
                        start_entry = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame configuration is frozen for the whole frame once the start bit is seen.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescale_l <= PRESCALE_W'(8);
            par_en_l   <= 1'b0;
            par_typ_l  <= PAR_EVEN;
        end else if (start_entry) begin
            prescale_l <= rx_if.Prescale;
            par_en_l   <= rx_if.PAR_EN;
            par_typ_l  <= rx_if.PAR_TYP;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_reg    <= '0;
            par_err_flag <= 1'b0;
        end else begin
            if (start_entry) begin
                par_err_flag <= 1'b0;
            end else if (bit_done && (state == ST_PARITY)) begin
                par_err_flag <= (sampled_bit != par_expected);
            end
            if (bit_done && (state == ST_DATA)) begin
                shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            if (bit_done && (state == ST_STOP)) begin
                if (!sampled_bit) stop_error_q <= 1'b1;
                if (par_err_flag) parity_error_q <= 1'b1;
                if (sampled_bit && !par_err_flag) begin
                    data_valid_q <= 1'b1;
                    p_data_q     <= shift_reg;
                end
            end
        end
    end

    assign rx_if.P_DATA       = p_data_q;
    assign rx_if.Data_Valid   = data_valid_q;
    assign rx_if.Parity_Error = parity_error_q;
    assign rx_if.Stop_Error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
    import uart_pkg::*;

    logic clk;
    logic rst;
    int   cyc;
    int   n_total;
    int   n_bad;

    uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) rx_if ();

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK   (clk),
        .RST   (rst),
        .rx_if (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         dv_cnt, pe_cnt, se_cnt;
    int         dv_last_cyc, dv_prev_cyc, pe_last_cyc, se_last_cyc;
    logic [7:0] dv_last_data, dv_prev_data;
    int         overlap_cnt, wide_cnt;
    logic       dv_d, pe_d, se_d;

    initial begin
        dv_cnt = 0; pe_cnt = 0; se_cnt = 0;
        dv_last_cyc = 0; dv_prev_cyc = 0; pe_last_cyc = 0; se_last_cyc = 0;
        dv_last_data = 8'h00; dv_prev_data = 8'h00;
        overlap_cnt = 0; wide_cnt = 0;
        dv_d = 1'b0; pe_d = 1'b0; se_d = 1'b0;
    end

    always @(negedge clk) begin
        if (rx_if.Data_Valid) begin
            dv_cnt++;
            dv_prev_cyc  = dv_last_cyc;
            dv_last_cyc  = cyc;
            dv_prev_data = dv_last_data;
            dv_last_data = rx_if.P_DATA;
        end
        if (rx_if.Parity_Error) begin
            pe_cnt++;
            pe_last_cyc = cyc;
        end
        if (rx_if.Stop_Error) begin
            se_cnt++;
            se_last_cyc = cyc;
        end
        if (rx_if.Data_Valid && (rx_if.Parity_Error || rx_if.Stop_Error)) overlap_cnt++;
        if ((rx_if.Data_Valid && dv_d) || (rx_if.Parity_Error && pe_d) || (rx_if.Stop_Error && se_d))
            wide_cnt++;
        dv_d = rx_if.Data_Valid;
        pe_d = rx_if.Parity_Error;
        se_d = rx_if.Stop_Error;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int p, input logic pe, input logic pt);
        rx_if.Prescale = 6'(p);
        rx_if.PAR_EN   = pe;
        rx_if.PAR_TYP  = pt;
    endtask

    task automatic idle(input int n);
        rx_if.RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; t0 is the cycle number of the first clock edge that sees the start bit.
    task automatic send_frame(input logic [7:0] data, input int p, input logic par_en,
                              input logic par_bit, input logic stop_bit, input logic mangle,
                              output int t0);
        t0 = cyc + 1;
        rx_if.RX_IN = 1'b0;
        repeat (p) @(negedge clk);
        if (mangle) set_cfg(8, ~rx_if.PAR_EN, ~rx_if.PAR_TYP);
        for (int i = 0; i < 8; i++) begin
            rx_if.RX_IN = data[i];
            repeat (p) @(negedge clk);
        end
        if (par_en) begin
            rx_if.RX_IN = par_bit;
            repeat (p) @(negedge clk);
        end
        rx_if.RX_IN = stop_bit;
        repeat (p) @(negedge clk);
    endtask

    int t0, t1;
    int dv0, pe0, se0;

    task automatic snap();
        dv0 = dv_cnt;
        pe0 = pe_cnt;
        se0 = se_cnt;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b0;
        rx_if.RX_IN = 1'b1;
        set_cfg(8, 1'b0, PAR_EVEN);
        repeat (3) @(negedge clk);
        check_eq("rst_p_data", 32'(rx_if.P_DATA), 32'h0);
        check_eq("rst_pulses", 32'({rx_if.Data_Valid, rx_if.Parity_Error, rx_if.Stop_Error}), 32'h0);
        check_eq("rst_state", 32'(dut.state), 32'(ST_IDLE));
        rst = 1'b1;
        idle(5);

        // 0xA5, Prescale 8, no parity: Data_Valid 80 cycles after the start edge
        snap();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        idle(6);
        check_eq("p8_dv_cnt", 32'(dv_cnt - dv0), 32'd1);
        check_eq("p8_data", 32'(rx_if.P_DATA), 32'hA5);
        check_eq("p8_latency", 32'(dv_last_cyc - t0), 32'd80);
        check_eq("p8_no_err", 32'((pe_cnt - pe0) + (se_cnt - se0)), 32'd0);

        // 0x3C even parity with wrong parity bit 1
        set_cfg(16, 1'b1, PAR_EVEN);
        snap();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0, t0);
        idle(6);
        check_eq("par_pe_cnt", 32'(pe_cnt - pe0), 32'd1);
        check_eq("par_pe_time", 32'(pe_last_cyc - t0), 32'd176);
        check_eq("par_no_dv_se", 32'((dv_cnt - dv0) + (se_cnt - se0)), 32'd0);
        check_eq("par_p_data_held", 32'(rx_if.P_DATA), 32'hA5);

        // 0x55 with stop bit 0, Prescale 32
        set_cfg(32, 1'b0, PAR_EVEN);
        snap();
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b0, 1'b0, t0);
        idle(6);
        check_eq("stop_se_cnt", 32'(se_cnt - se0), 32'd1);
        check_eq("stop_se_time", 32'(se_last_cyc - t0), 32'd320);
        check_eq("stop_no_dv_pe", 32'((dv_cnt - dv0) + (pe_cnt - pe0)), 32'd0);
        check_eq("stop_p_data_held", 32'(rx_if.P_DATA), 32'hA5);

        // Start glitch: low for 3 cycles, Prescale 16
        set_cfg(16, 1'b0, PAR_EVEN);
        snap();
        rx_if.RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        rx_if.RX_IN = 1'b1;
        repeat (13) @(negedge clk);
        check_eq("glitch_still_start", 32'(dut.state), 32'(ST_START));
        @(negedge clk);
        check_eq("glitch_idle_at_16", 32'(dut.state), 32'(ST_IDLE));
        idle(10);
        check_eq("glitch_no_pulses", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'd0);

        // Back-to-back 0x01 / 0xFF, odd parity, Prescale 8
        set_cfg(8, 1'b1, PAR_ODD);
        snap();
        send_frame(8'h01, 8, 1'b1, 1'b0, 1'b1, 1'b0, t0);
        send_frame(8'hFF, 8, 1'b1, 1'b1, 1'b1, 1'b0, t1);
        idle(6);
        check_eq("b2b_dv_cnt", 32'(dv_cnt - dv0), 32'd2);
        check_eq("b2b_gap", 32'(dv_last_cyc - dv_prev_cyc), 32'd88);
        check_eq("b2b_first", 32'(dv_prev_data), 32'h01);
        check_eq("b2b_second", 32'(dv_last_data), 32'hFF);
        check_eq("b2b_no_err", 32'((pe_cnt - pe0) + (se_cnt - se0)), 32'd0);

        // Mid-frame config changes must not affect the frame in flight
        set_cfg(16, 1'b1, PAR_ODD);
        snap();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b1, t0);
        idle(6);
        check_eq("latch_dv_cnt", 32'(dv_cnt - dv0), 32'd1);
        check_eq("latch_data", 32'(rx_if.P_DATA), 32'h3C);
        check_eq("latch_latency", 32'(dv_last_cyc - t0), 32'd176);

        // Reset during data bit 4, then a clean 0x81
        set_cfg(8, 1'b0, PAR_EVEN);
        snap();
        rx_if.RX_IN = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_if.RX_IN = 1'b1;
            repeat (8) @(negedge clk);
        end
        rx_if.RX_IN = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midrst_p_data", 32'(rx_if.P_DATA), 32'h0);
        rst = 1'b1;
        idle(20);
        check_eq("midrst_no_pulses", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'd0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        idle(6);
        check_eq("midrst_dv_cnt", 32'(dv_cnt - dv0), 32'd1);
        check_eq("midrst_data", 32'(rx_if.P_DATA), 32'h81);
        check_eq("midrst_latency", 32'(dv_last_cyc - t0), 32'd80);

        check_eq("dv_err_overlap", 32'(overlap_cnt), 32'd0);
        check_eq("pulse_width", 32'(wide_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
